clk_divider_prog: RTL and testbench
===================================

// Module: clk_divider_prog
// PURPOSE
//  Runtime-programmable integer clock divider: period and high time load while running, applied glitch-free at the period boundary.
//  Drives LED-matrix scan/shift timing from the fabric clock.
//  Adds enable, a period-start strobe and load acknowledge.
// PARAMETERS
//  WIDTH        16     width of divisor/high-time fields and of the internal counter
//  DEFAULT_DIV  12500  divisor (period in i_clk cycles) after reset
//  DEFAULT_HIGH 6250   o_clk high cycles per period after reset
// PORTS
//  i_clk       in   1      sole clock, rising edge
//  i_rst_n     in   1      asynchronous, active-low reset
//  i_en        in   1      run enable; low = stopped, outputs low
//  i_div       in   WIDTH  requested period in cycles, sampled on i_load
//  i_high      in   WIDTH  requested high cycles, sampled on i_load
//  i_load      in   1      one-cycle strobe: capture i_div/i_high into pending
//  o_clk       out  1      divided clock, registered
//  o_tick      out  1      one-cycle pulse in the first cycle of every period
//  o_load_ack  out  1      one-cycle pulse in the cycle new values take effect
//  o_active    out  1      1 while in RUN
// BEHAVIOUR
//  Reset (async assert, sync to i_clk on release). State=IDLE, cnt=0, o_clk=0, o_tick=0, o_load_ack=0, pending=0.
//    Also div_q=DEFAULT_DIV, high_q=DEFAULT_HIGH.
//  Clamping at capture, via the clamp function in clk_div_pkg: div_eff=max(i_div,2); high_eff=min(max(i_high,1),div_eff-1).
//    Hence o_clk always toggles.
//  FSM IDLE/RUN, one transition per edge:
//   IDLE & i_en=1 -> RUN: cnt<=0, o_clk<=1, o_tick<=1 (1-cycle latency from i_en).
//   RUN  & i_en=1: cnt_nxt = (cnt==div_q-1) ? 0 : cnt+1.
//     o_clk<=(cnt_nxt<high_q); o_tick<=(cnt_nxt==0).
//   RUN  & i_en=0 -> IDLE: cnt<=0, o_clk<=0, o_tick<=0. The current period is truncated with no extra edges.
//   IDLE & i_en=0: hold, outputs 0.
//  Result: period = div_q cycles, o_clk high for exactly high_q cycles, starting at the o_tick cycle.
//  Load:
//   i_load captures clamped values into pend_div/pend_high and sets pending.
//   A repeated i_load while pending overwrites; one ack results.
//   In RUN, pending is applied on the wrap edge (cnt_nxt==0). o_clk/o_tick for the new period use the new values.
//     o_load_ack=1 coincides with that o_tick.
//   In IDLE, pending is applied on the next edge; o_load_ack pulses there.
//   i_load on the wrap edge itself: the i_load values bypass pending, are applied at that wrap, and are acked there.
//   i_load on the IDLE->RUN edge: applied at that edge; first period uses the new values.
//  Counter never exceeds div_q-1. A shrinking div takes effect only at wrap, so cnt cannot run past the new limit.
//  i_div/i_high are ignored except on i_load; no other input timing constraint.
// CONFIGURATION
//  Macro CLK_DIVIDER_PROG_FALL_TICK_EN.
//   Defined: adds port o_fall_tick (out, 1). It pulses in the first low cycle of each period, i.e. when cnt_nxt==high_q in RUN.
//     Reset/IDLE value is 0.
//   Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  clk_div_pkg holds:
//   - state localparams ST_IDLE/ST_RUN
//   - function clamp_div and function clamp_high
//   - default-width constant
//  Sub-module clk_div_cfg_shadow holds pend/active registers, pending flag, bypass and ack generation.
//    Inputs: load, apply_now. Outputs: div_q, high_q, ack.
//  Top holds the FSM, counter and output registers.
// TESTING
//  1. Reset then i_en=1 with defaults -> o_tick every 12500 cycles; o_clk high 6250, low 6250; first o_clk=1 one cycle after i_en.
//  2. DIV=5/HIGH=2 loaded in IDLE, then run -> o_clk 11000 repeating; o_load_ack before start; o_tick on each leading 1.
//  3. Running 5/2, i_load 8/3 at cnt=1 -> current period finishes as 5/2; next period is 8/3 with o_load_ack on its o_tick.
//  4. i_load with i_div=0, i_high=9 -> effective 2/1: o_clk alternates 1,0; i_high=0 with div 4 -> high 1.
//  5. Deassert i_en mid-high, reassert 3 cycles later -> o_clk 0 next edge; restart at cnt=0 with o_tick; o_active tracks FSM.
//  6. Assert i_rst_n=0 mid-period with 8/3 loaded -> all outputs 0 immediately; after release, defaults 12500/6250 are in force.
//     With CLK_DIVIDER_PROG_FALL_TICK_EN defined, check o_fall_tick at cycle high_q of every period.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM states,
// default field width and the divisor/high-time clamp helpers.
package clk_div_pkg;

  // Default width of the divisor, high-time and counter fields.
  localparam int CLK_DIV_WIDTH = 16;

  // Divider run states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } clk_div_state_t;

  // Smallest legal period is 2 cycles so the output can toggle.
  function automatic logic [31:0] clamp_div(input logic [31:0] div_in);
    logic [31:0] div_eff;
    if (div_in < 32'd2) begin
      div_eff = 32'd2;
    end else begin
      div_eff = div_in;
    end
    return div_eff;
  endfunction

  // High time is kept within 1 .. div_eff-1 so both levels appear each period.
  function automatic logic [31:0] clamp_high(input logic [31:0] high_in,
                                             input logic [31:0] div_eff);
    logic [31:0] high_eff;
    if (high_in < 32'd1) begin
      high_eff = 32'd1;
    end else if (high_in > (div_eff - 32'd1)) begin
      high_eff = div_eff - 32'd1;
    end else begin
      high_eff = high_in;
    end
    return high_eff;
  endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Shadow configuration for the clock divider. Requested values are clamped
// and parked in a pending slot; the active divisor/high time only change
// when the top signals apply_now (period boundary or idle). A load that
// lands on an apply edge bypasses the pending slot. ack pulses for one
// cycle each time new values become active.
import clk_div_pkg::*;

module clk_div_cfg_shadow #(
  parameter int WIDTH        = CLK_DIV_WIDTH,
  parameter int DEFAULT_DIV  = 12500,
  parameter int DEFAULT_HIGH = 6250
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             apply_now,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] high_q,
  output logic             ack
);

  logic [WIDTH-1:0] div_eff_s;
  logic [WIDTH-1:0] high_eff_s;
  logic [WIDTH-1:0] pend_div_r;
  logic [WIDTH-1:0] pend_high_r;
  logic             pending_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] high_r;
  logic             ack_r;

  // Clamp the requested values as they are presented.
  always_comb begin
    div_eff_s  = WIDTH'(clamp_div(32'(div_in)));
    high_eff_s = WIDTH'(clamp_high(32'(high_in), 32'(div_eff_s)));
  end

  // Pending slot, active values and the one-cycle acknowledge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_div_r  <= WIDTH'(0);
      pend_high_r <= WIDTH'(0);
      pending_r   <= 1'b0;
      div_r       <= WIDTH'(DEFAULT_DIV);
      high_r      <= WIDTH'(DEFAULT_HIGH);
      ack_r       <= 1'b0;
    end else if (apply_now) begin
      if (load) begin
        div_r     <= div_eff_s;
        high_r    <= high_eff_s;
        pending_r <= 1'b0;
        ack_r     <= 1'b1;
      end else if (pending_r) begin
        div_r     <= pend_div_r;
        high_r    <= pend_high_r;
        pending_r <= 1'b0;
        ack_r     <= 1'b1;
      end else begin
        ack_r     <= 1'b0;
      end
    end else begin
      if (load) begin
        pend_div_r  <= div_eff_s;
        pend_high_r <= high_eff_s;
        pending_r   <= 1'b1;
      end else begin
        pending_r   <= pending_r;
      end
      ack_r <= 1'b0;
    end
  end

  assign div_q  = div_r;
  assign high_q = high_r;
  assign ack    = ack_r;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider for LED-matrix scan timing.
// Period and high time can be reloaded while running; new values take
// effect only at the period boundary, so o_clk never glitches.
// Optional feature macro: CLK_DIVIDER_PROG_FALL_TICK_EN adds o_fall_tick,
// a one-cycle pulse in the first low cycle of every period.
import clk_div_pkg::*;

module clk_divider_prog #(
  parameter int WIDTH        = CLK_DIV_WIDTH,
  parameter int DEFAULT_DIV  = 12500,
  parameter int DEFAULT_HIGH = 6250
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic [WIDTH-1:0] i_high,
  input  logic             i_load,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_load_ack,
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
  output logic             o_fall_tick,
`endif
  output logic             o_active
);

  clk_div_state_t   state_r;
  clk_div_state_t   state_nxt_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] cnt_wrap_s;
  logic             clk_r;
  logic             clk_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;
  logic             apply_now_s;
  logic [WIDTH-1:0] div_q_s;
  logic [WIDTH-1:0] high_q_s;
  logic             ack_s;
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
  logic             fall_r;
  logic             fall_nxt_s;
`endif

  clk_div_cfg_shadow #(
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_HIGH (DEFAULT_HIGH)
  ) u_cfg_shadow (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .load      (i_load),
    .div_in    (i_div),
    .high_in   (i_high),
    .apply_now (apply_now_s),
    .div_q     (div_q_s),
    .high_q    (high_q_s),
    .ack       (ack_s)
  );

  // Free-running counter successor: wraps to zero at the end of the period.
  always_comb begin
    if (cnt_r == (div_q_s - WIDTH'(1))) begin
      cnt_wrap_s = WIDTH'(0);
    end else begin
      cnt_wrap_s = cnt_r + WIDTH'(1);
    end
  end

  // Next state, counter and output levels; config applies in IDLE or at wrap.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    clk_nxt_s   = 1'b0;
    tick_nxt_s  = 1'b0;
    apply_now_s = 1'b0;
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
    fall_nxt_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        apply_now_s = 1'b1;
        if (i_en) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = WIDTH'(0);
          clk_nxt_s   = 1'b1;
          tick_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = WIDTH'(0);
        end
      end
      ST_RUN: begin
        if (i_en) begin
          cnt_nxt_s   = cnt_wrap_s;
          clk_nxt_s   = (cnt_wrap_s < high_q_s);
          tick_nxt_s  = (cnt_wrap_s == WIDTH'(0));
          apply_now_s = (cnt_wrap_s == WIDTH'(0));
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
          fall_nxt_s  = (cnt_wrap_s == high_q_s);
`endif
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = WIDTH'(0);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = WIDTH'(0);
      end
    endcase
  end

  // State, counter and registered output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= WIDTH'(0);
      clk_r   <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      clk_r   <= clk_nxt_s;
      tick_r  <= tick_nxt_s;
    end
  end

`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
  // First-low-cycle strobe register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fall_r <= 1'b0;
    end else begin
      fall_r <= fall_nxt_s;
    end
  end

  assign o_fall_tick = fall_r;
`endif

  assign o_clk      = clk_r;
  assign o_tick     = tick_r;
  assign o_load_ack = ack_s;
  assign o_active   = (state_r == ST_RUN);

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog. Outputs are sampled on
// the falling edge of i_clk; inputs change right after that sample.
// Optional feature macro: CLK_DIVIDER_PROG_FALL_TICK_EN.
module tb_clk_divider_prog;

  localparam int W = 16;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_en;
  logic [W-1:0] i_div;
  logic [W-1:0] i_high;
  logic         i_load;
  logic         o_clk;
  logic         o_tick;
  logic         o_load_ack;
  logic         o_active;
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
  logic         o_fall_tick;
`endif

  int n_cmp;
  int n_err;

  clk_divider_prog #(
    .WIDTH        (W),
    .DEFAULT_DIV  (12500),
    .DEFAULT_HIGH (6250)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_div      (i_div),
    .i_high     (i_high),
    .i_load     (i_load),
    .o_clk      (o_clk),
    .o_tick     (o_tick),
    .o_load_ack (o_load_ack),
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
    .o_fall_tick(o_fall_tick),
`endif
    .o_active   (o_active)
  );

  // 100 MHz fabric clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic do_load(input int div, input int high);
    i_load = 1'b1;
    i_div  = W'(div);
    i_high = W'(high);
  endtask

  // Step until o_tick is seen, bounded.
  task automatic wait_tick(input string tag, input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tick && n < bound);
    chk_val(tag, 32'(o_tick), 32'd1);
  endtask

  // Starting on a tick cycle, observe one full period and the next tick.
  task automatic measure_period(input string tag, input int exp_div, input int exp_high);
    int highs;
    int first_low;
    int extra;
    int fall_idx;
    int fall_cnt;
    highs = 0; first_low = -1; extra = 0; fall_idx = -1; fall_cnt = 0;
    for (int i = 0; i < exp_div; i++) begin
      if (o_clk) highs++;
      else if (first_low < 0) first_low = i;
      if (i > 0 && o_tick) extra++;
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
      if (o_fall_tick) begin
        fall_cnt++;
        if (fall_idx < 0) fall_idx = i;
      end
`endif
      step();
    end
    chk_val({tag, "_high_cnt"}, 32'(highs), 32'(exp_high));
    chk_val({tag, "_first_low"}, 32'(first_low), 32'(exp_high));
    chk_val({tag, "_extra_tick"}, 32'(extra), 32'd0);
    chk_val({tag, "_next_tick"}, 32'(o_tick), 32'd1);
`ifdef CLK_DIVIDER_PROG_FALL_TICK_EN
    chk_val({tag, "_fall_idx"}, 32'(fall_idx), 32'(exp_high));
    chk_val({tag, "_fall_cnt"}, 32'(fall_cnt), 32'd1);
`else
    chk_val({tag, "_fall_none"}, 32'(fall_cnt + fall_idx), 32'hFFFF_FFFF);
`endif
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    i_rst_n = 1'b0; i_en = 1'b0; i_load = 1'b0;
    i_div = W'(0); i_high = W'(0);

    // Reset state
    step(); step();
    chk_val("rst_clk", 32'(o_clk), 32'd0);
    chk_val("rst_tick", 32'(o_tick), 32'd0);
    chk_val("rst_ack", 32'(o_load_ack), 32'd0);
    chk_val("rst_active", 32'(o_active), 32'd0);
    i_rst_n = 1'b1;
    step();
    chk_val("idle_ack", 32'(o_load_ack), 32'd0);
    chk_val("idle_clk", 32'(o_clk), 32'd0);

    // 1: defaults after reset
    i_en = 1'b1;
    step();
    chk_val("t1_start_clk", 32'(o_clk), 32'd1);
    chk_val("t1_start_tick", 32'(o_tick), 32'd1);
    chk_val("t1_active", 32'(o_active), 32'd1);
    measure_period("t1_dflt", 12500, 6250);

    // 2: load 5/2 in IDLE, then run
    i_en = 1'b0;
    step();
    chk_val("t2_stop_clk", 32'(o_clk), 32'd0);
    chk_val("t2_stop_active", 32'(o_active), 32'd0);
    do_load(5, 2);
    step();
    i_load = 1'b0;
    chk_val("t2_idle_ack", 32'(o_load_ack), 32'd1);
    chk_val("t2_idle_clk", 32'(o_clk), 32'd0);
    i_en = 1'b1;
    step();
    chk_val("t2_start_tick", 32'(o_tick), 32'd1);
    chk_val("t2_start_ack", 32'(o_load_ack), 32'd0);
    measure_period("t2_p1", 5, 2);
    measure_period("t2_p2", 5, 2);

    // 3: load 8/3 at cnt=1 while running 5/2
    step();
    chk_val("t3_cnt1_clk", 32'(o_clk), 32'd1);
    do_load(8, 3);
    step();
    i_load = 1'b0;
    chk_val("t3_cnt2_clk", 32'(o_clk), 32'd0);
    chk_val("t3_cnt2_ack", 32'(o_load_ack), 32'd0);
    step(); step();
    chk_val("t3_cnt4_clk", 32'(o_clk), 32'd0);
    chk_val("t3_cnt4_tick", 32'(o_tick), 32'd0);
    step();
    chk_val("t3_wrap_tick", 32'(o_tick), 32'd1);
    chk_val("t3_wrap_ack", 32'(o_load_ack), 32'd1);
    measure_period("t3_new", 8, 3);
    chk_val("t3_ack_once", 32'(o_load_ack), 32'd0);

    // 4: clamping div=0/high=9 -> 2/1, then div=4/high=0 -> 4/1
    do_load(0, 9);
    step();
    i_load = 1'b0;
    wait_tick("t4a_wait", 20);
    chk_val("t4a_ack", 32'(o_load_ack), 32'd1);
    measure_period("t4a_p1", 2, 1);
    measure_period("t4a_p2", 2, 1);
    do_load(4, 0);
    step();
    i_load = 1'b0;
    wait_tick("t4b_wait", 20);
    chk_val("t4b_ack", 32'(o_load_ack), 32'd1);
    measure_period("t4b", 4, 1);

    // Load on the wrap edge itself bypasses pending
    step(); step(); step();
    chk_val("byp_last_tick", 32'(o_tick), 32'd0);
    do_load(3, 2);
    step();
    i_load = 1'b0;
    chk_val("byp_tick", 32'(o_tick), 32'd1);
    chk_val("byp_ack", 32'(o_load_ack), 32'd1);
    measure_period("byp", 3, 2);

    // Repeated load while pending: last wins, single ack
    do_load(6, 5);
    step();
    do_load(5, 3);
    step();
    i_load = 1'b0;
    chk_val("ovr_no_early_ack", 32'(o_load_ack), 32'd0);
    step();
    chk_val("ovr_tick", 32'(o_tick), 32'd1);
    chk_val("ovr_ack", 32'(o_load_ack), 32'd1);
    measure_period("ovr", 5, 3);
    chk_val("ovr_ack_once", 32'(o_load_ack), 32'd0);

    // 5: drop enable mid-high, reassert three cycles later
    step();
    chk_val("t5_mid_high", 32'(o_clk), 32'd1);
    i_en = 1'b0;
    step();
    chk_val("t5_off_clk", 32'(o_clk), 32'd0);
    chk_val("t5_off_tick", 32'(o_tick), 32'd0);
    chk_val("t5_off_active", 32'(o_active), 32'd0);
    step(); step();
    chk_val("t5_held_clk", 32'(o_clk), 32'd0);
    i_en = 1'b1;
    step();
    chk_val("t5_re_tick", 32'(o_tick), 32'd1);
    chk_val("t5_re_clk", 32'(o_clk), 32'd1);
    chk_val("t5_re_active", 32'(o_active), 32'd1);
    measure_period("t5", 5, 3);

    // 6: async reset mid-period with 8/3 loaded
    do_load(8, 3);
    step();
    i_load = 1'b0;
    wait_tick("t6_wait", 20);
    chk_val("t6_ack", 32'(o_load_ack), 32'd1);
    step(); step();
    chk_val("t6_pre_clk", 32'(o_clk), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk_val("t6_rst_clk", 32'(o_clk), 32'd0);
    chk_val("t6_rst_tick", 32'(o_tick), 32'd0);
    chk_val("t6_rst_ack", 32'(o_load_ack), 32'd0);
    chk_val("t6_rst_active", 32'(o_active), 32'd0);
    step();
    i_rst_n = 1'b1;
    step();
    chk_val("t6_restart_tick", 32'(o_tick), 32'd1);
    chk_val("t6_restart_ack", 32'(o_load_ack), 32'd0);
    measure_period("t6_dflt", 12500, 6250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
